axi_aw_w_arb_ctrl: RTL and testbench
====================================

# axi_aw_w_arb_ctrl

Write-path arbitration controller for an N:1 AXI merge point, for example one master port of the crossbar fabric fed by several slave ports. It round-robin arbitrates AW requests and records each granted requester index in an order FIFO. It then steers the W channel from the head-of-FIFO requester until WLAST, so W bursts leave in AW order. The block drives only handshakes and select indices; payload muxes are external and use `aw_sel_o`/`w_sel_o`.

## Interface
- `NUM_SLAVES`, 2: number of requesting slave ports (≥2).
- `IDX_FIFO_DEPTH`, 4: outstanding AW grants whose W bursts are not yet complete (≥1, power of two).
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset. Reset is synchronous and active-high.
- `slv_aw_valid_i` in NUM_SLAVES: per-requester AWVALID.
- `slv_aw_ready_o` out NUM_SLAVES: per-requester AWREADY.
- `mst_aw_valid_o` out 1: merged AWVALID.
- `mst_aw_ready_i` in 1: merged AWREADY.
- `aw_sel_o` out IDX_W: AW payload mux select, with IDX_W = max(1, $clog2(NUM_SLAVES)).
- `slv_w_valid_i` in NUM_SLAVES: per-requester WVALID.
- `slv_w_last_i` in NUM_SLAVES: per-requester WLAST.
- `slv_w_ready_o` out NUM_SLAVES: per-requester WREADY.
- `mst_w_valid_o` out 1: merged WVALID.
- `mst_w_ready_i` in 1: merged WREADY.
- `w_sel_o` out IDX_W: W payload mux select; equals the FIFO head.
- `fifo_full_o` out 1: order FIFO full.
- `fifo_empty_o` out 1: order FIFO empty.

## Operation
- AW state machine has two states, IDLE and HOLD.
  - IDLE: if `!fifo_full` and any `slv_aw_valid_i` is set, pick the first requester at or after the priority pointer `prio`, wrapping modulo NUM_SLAVES. Assert `mst_aw_valid_o` combinationally with `aw_sel_o` = winner.
  - IDLE, handshake in the same cycle: push the winner, set `prio` = winner+1 (wrapping NUM_SLAVES-1 → 0), stay in IDLE.
  - IDLE, no handshake: latch the winner into `aw_lock` and go to HOLD.
  - HOLD: `aw_sel_o` = `aw_lock` and `mst_aw_valid_o` = 1. No re-arbitration even if higher-priority requesters assert (AXI valid stability). On `mst_aw_ready_i`: push, update `prio`, return to IDLE.
- `slv_aw_ready_o[k]` = `mst_aw_ready_i` & `mst_aw_valid_o` & (`aw_sel_o`==k). All other bits are 0.
- FIFO full: no new arbitration in IDLE; `mst_aw_valid_o`=0. HOLD is never entered while full. A push in HOLD is guaranteed because HOLD is entered only when not full and pops cannot fill the FIFO.
- Push while full in the same cycle as a pop is not allowed. Fullness is evaluated on the registered count, so AW resumes the cycle after the pop.
- W path:
  - `mst_w_valid_o` = `!fifo_empty` & `slv_w_valid_i[head]`.
  - `slv_w_ready_o[head]` = `mst_w_ready_i` & `!fifo_empty`. All other bits are 0.
  - Pop on a W handshake with `slv_w_last_i[head]`=1.
  - Non-last beats do not change state.
- Simultaneous push and pop with the FIFO not full: count is unchanged, and head and tail both advance.
- Counters and arithmetic:
  - Count width is $clog2(IDX_FIFO_DEPTH+1).
  - Read and write pointers are $clog2(IDX_FIFO_DEPTH) bits and wrap naturally.
  - `prio` is IDX_W bits with explicit wrap at NUM_SLAVES.

## Timing
- Reset values: state IDLE, `prio`=0, `aw_lock`=0, FIFO empty, count 0, `fifo_empty_o`=1, `fifo_full_o`=0.
- With no valids asserted, all valid/ready outputs are 0 and `aw_sel_o`=`w_sel_o`=0.
- AW path is combinational valid→valid (0 cycles). Grant state updates at the next edge.
- Without fall-through, the earliest W acceptance for a burst is the cycle after its AW handshake.
- Reset asserted mid-burst: all state clears at that edge. Outstanding indices are discarded; the surrounding system must be reset together.

## Configuration
- `AXI_AW_W_ARB_FALLTHROUGH_EN` defined: when the FIFO is empty and an AW handshake occurs, the W path uses the current winner as head in the same cycle.
  - A single-beat W with WLAST in that cycle completes without a push (net: no push, no pop).
  - A non-last beat in that cycle still pushes the index.
- `AXI_AW_W_ARB_FALLTHROUGH_EN` undefined: W waits one cycle after the AW handshake, as in Timing.

## Structure
- `axi_pkg` gains `arb_idx_width(n)`, returning max(1, $clog2(n)), used by this block and by payload mux wrappers.
- One sub-module, `axi_aw_w_idx_fifo`:
  - Parameterised depth and width.
  - Push/pop, full/empty, head output.
  - Registered count.
- Arbitration and W steering stay in the top.

## Test plan
- Reset, then idle with all inputs 0 → all valid/ready outputs 0, `fifo_empty_o`=1, selects 0.
- NUM_SLAVES=3, requesters 0/1/2 hold AWVALID, `mst_aw_ready_i`=1 → grants 0,1,2,0 on consecutive cycles; W bursts (lengths 2,1,3) are accepted strictly in order 0,1,2.
- Requester 1 wins, `mst_aw_ready_i`=0 for 3 cycles while requester 0 asserts → `aw_sel_o` stays 1 for all 3 cycles; grant to 1 occurs on ready, and the next grant goes to 2 if valid, else 0.
- Depth 4, W ready held low, 5 AWs offered → 4 accepted, `fifo_full_o`=1, `mst_aw_valid_o`=0. After one WLAST pop, the 5th AW is accepted the following cycle.
- Same cycle push+pop at count 2 → count stays 2; head advances to the next index.
- Fall-through: with the macro defined, FIFO empty, AW and single-beat W in the same cycle → both handshake in that cycle and FIFO stays empty. With the macro undefined, W ready is 0 that cycle and the W handshake occurs one cycle later.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI helpers: arbitration index sizing, modular increment, and the AW
// arbiter state type used by the write-path merge controller.
package axi_pkg;

  typedef enum logic {
    AW_IDLE = 1'b0,
    AW_HOLD = 1'b1
  } aw_state_e;

  // Select width for an n-way payload mux; a 1:1 mux still needs one bit.
  function automatic int arb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for operands already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/axi_aw_w_idx_fifo.sv
// Order FIFO holding granted requester indices until their W burst completes.
// Full/empty are decoded from a registered occupancy count.
module axi_aw_w_idx_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = arb_idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap on overflow; depth 1 pins them.
    if (push_i) wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + PTR_W'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read while the
  // count says it holds live data.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_aw_w_arb_ctrl.sv
// N:1 AXI write-path merge controller: round-robin AW arbitration and W steering
// in AW order. Define AXI_AW_W_ARB_FALLTHROUGH_EN for same-cycle W on an empty FIFO.
module axi_aw_w_arb_ctrl
  import axi_pkg::*;
#(
  parameter int  NUM_SLAVES     = 2,
  parameter int  IDX_FIFO_DEPTH = 4,
  localparam int IDX_W          = arb_idx_width(NUM_SLAVES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_SLAVES-1:0] slv_aw_valid_i,
  output logic [NUM_SLAVES-1:0] slv_aw_ready_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [IDX_W-1:0]      aw_sel_o,
  input  logic [NUM_SLAVES-1:0] slv_w_valid_i,
  input  logic [NUM_SLAVES-1:0] slv_w_last_i,
  output logic [NUM_SLAVES-1:0] slv_w_ready_o,
  output logic                  mst_w_valid_o,
  input  logic                  mst_w_ready_i,
  output logic [IDX_W-1:0]      w_sel_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o
);

  aw_state_e        state_q, state_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] aw_lock_q, aw_lock_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             aw_hs;
  logic             ft_active;
  logic             w_active;
  logic [IDX_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             w_last_hs;
  logic             fifo_push;
  logic             fifo_pop;

  // Round-robin search: first valid requester at or after prio_q.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      cand = IDX_W'(wrap_add(int'(prio_q), i, NUM_SLAVES));
      if (!found && slv_aw_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    aw_lock_d      = aw_lock_q;
    mst_aw_valid_o = 1'b0;
    aw_sel_o       = '0;
    slv_aw_ready_o = '0;
    unique case (state_q)
      AW_IDLE: begin
        if (!fifo_full && found) begin
          mst_aw_valid_o = 1'b1;
          aw_sel_o       = winner;
          if (!mst_aw_ready_i) begin
            state_d   = AW_HOLD;
            aw_lock_d = winner;
          end
        end
      end
      AW_HOLD: begin
        // Once offered, AWVALID and its payload must not change until accepted.
        mst_aw_valid_o = 1'b1;
        aw_sel_o       = aw_lock_q;
        if (mst_aw_ready_i) state_d = AW_IDLE;
      end
      default: state_d = AW_IDLE;
    endcase
    aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    if (aw_hs) begin
      prio_d                   = IDX_W'(wrap_add(int'(aw_sel_o), 1, NUM_SLAVES));
      slv_aw_ready_o[aw_sel_o] = 1'b1;
    end
  end

`ifdef AXI_AW_W_ARB_FALLTHROUGH_EN
  assign ft_active = fifo_empty & aw_hs;
`else
  assign ft_active = 1'b0;
`endif

  always_comb begin
    w_sel_o        = ft_active ? aw_sel_o : fifo_head;
    w_active       = !fifo_empty || ft_active;
    mst_w_valid_o  = w_active & slv_w_valid_i[w_sel_o];
    slv_w_ready_o  = '0;
    slv_w_ready_o[w_sel_o] = mst_w_ready_i & w_active;
    w_last_hs      = mst_w_valid_o & mst_w_ready_i & slv_w_last_i[w_sel_o];
    // A fall-through burst that ends in its AW cycle never occupies the FIFO.
    fifo_push      = aw_hs & !(ft_active & w_last_hs);
    fifo_pop       = w_last_hs & !fifo_empty;
  end

  assign fifo_full_o  = fifo_full;
  assign fifo_empty_o = fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= AW_IDLE;
      prio_q    <= '0;
      aw_lock_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      aw_lock_q <= aw_lock_d;
    end
  end

  axi_aw_w_idx_fifo #(
    .DEPTH (IDX_FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (aw_sel_o),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_axi_aw_w_arb_ctrl.sv
// Directed bench for axi_aw_w_arb_ctrl (3 requesters, depth 4) with a queue-based
// reference model compared every cycle plus literal expectations per scenario.
module tb_axi_aw_w_arb_ctrl;

  localparam int NS    = 3;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
`ifdef AXI_AW_W_ARB_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NS-1:0] awv, awr_o, wv, wl, wr_o;
  logic          awr, wr;
  logic          m_awv, m_wv, full, empty;
  logic [IW-1:0] aw_sel, w_sel;

  int errors;
  int checks;

  axi_aw_w_arb_ctrl #(
    .NUM_SLAVES     (NS),
    .IDX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .slv_aw_valid_i (awv),
    .slv_aw_ready_o (awr_o),
    .mst_aw_valid_o (m_awv),
    .mst_aw_ready_i (awr),
    .aw_sel_o       (aw_sel),
    .slv_w_valid_i  (wv),
    .slv_w_last_i   (wl),
    .slv_w_ready_o  (wr_o),
    .mst_w_valid_o  (m_wv),
    .mst_w_ready_i  (wr),
    .w_sel_o        (w_sel),
    .fifo_full_o    (full),
    .fifo_empty_o   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Order of outstanding grants, round-robin pointer, and an AW offer that
  // must stay put until accepted (-1 when none is pending).
  int q[$];
  int m_prio;
  int m_pend;
  bit m_on;

  initial begin
    m_on   = 1'b0;
    m_prio = 0;
    m_pend = -1;
  end

  always @(negedge clk) begin
    bit e_full, e_empty, e_awv, e_awhs, e_ft, e_wact, e_mwv, e_last_hs;
    int e_sel, e_whead, e_swr, e_sar, c;
    e_full  = (q.size() == DEPTH);
    e_empty = (q.size() == 0);
    e_awv   = 1'b0;
    e_sel   = 0;
    if (m_pend >= 0) begin
      e_awv = 1'b1;
      e_sel = m_pend;
    end else if (!e_full && awv != '0) begin
      for (int k = 0; k < NS; k++) begin
        c = (m_prio + k) % NS;
        if (!e_awv && ((awv >> c) & 1) != 0) begin
          e_awv = 1'b1;
          e_sel = c;
        end
      end
    end
    e_awhs    = e_awv && awr;
    e_ft      = FT && e_empty && e_awhs;
    e_wact    = !e_empty || e_ft;
    e_whead   = e_ft ? e_sel : (e_empty ? 0 : q[0]);
    e_mwv     = e_wact && (((wv >> e_whead) & 1) != 0);
    e_swr     = (e_wact && wr) ? (1 << e_whead) : 0;
    e_sar     = e_awhs ? (1 << e_sel) : 0;
    e_last_hs = e_mwv && wr && (((wl >> e_whead) & 1) != 0);

    if (m_on) begin
      check("m_aw_valid", 32'(m_awv), 32'(e_awv));
      check("m_aw_sel", 32'(aw_sel), 32'(e_sel));
      check("m_slv_aw_ready", 32'(awr_o), 32'(e_sar));
      check("m_w_valid", 32'(m_wv), 32'(e_mwv));
      check("m_w_sel", 32'(w_sel), 32'(e_whead));
      check("m_slv_w_ready", 32'(wr_o), 32'(e_swr));
      check("m_full", 32'(full), 32'(e_full));
      check("m_empty", 32'(empty), 32'(e_empty));
    end

    if (rst) begin
      q.delete();
      m_prio = 0;
      m_pend = -1;
      m_on   = 1'b1;
    end else if (m_on) begin
      if (e_last_hs && !e_empty) void'(q.pop_front());
      if (e_awhs) begin
        m_prio = (e_sel + 1) % NS;
        m_pend = -1;
        if (!(e_ft && e_last_hs)) q.push_back(e_sel);
      end else if (e_awv) begin
        m_pend = e_sel;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [NS-1:0] a_v, input logic a_r,
                       input logic [NS-1:0] w_v, input logic [NS-1:0] w_l, input logic w_r);
    @(posedge clk);
    #1;
    rst = r;
    awv = a_v;
    awr = a_r;
    wv  = w_v;
    wl  = w_l;
    wr  = w_r;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; awv = '0; awr = 1'b0; wv = '0; wl = '0; wr = 1'b0;

    // Reset, then idle.
    drive(1, 3'b000, 0, 3'b000, 3'b000, 0);
    drive(1, 3'b000, 0, 3'b000, 3'b000, 0);
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);
    check("idle_aw_valid", 32'(m_awv), 0);
    check("idle_w_valid", 32'(m_wv), 0);
    check("idle_aw_ready", 32'(awr_o), 0);
    check("idle_w_ready", 32'(wr_o), 0);
    check("idle_empty", 32'(empty), 1);
    check("idle_full", 32'(full), 0);
    check("idle_aw_sel", 32'(aw_sel), 0);
    check("idle_w_sel", 32'(w_sel), 0);

    // All requesters valid, ready high: grants 0,1,2,0 back to back.
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("rr_g0_sel", 32'(aw_sel), 0);
    check("rr_g0_ready", 32'(awr_o), 32'b001);
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("rr_g1_sel", 32'(aw_sel), 1);
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("rr_g2_sel", 32'(aw_sel), 2);
    check("rr_g2_ready", 32'(awr_o), 32'b100);
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("rr_g3_sel", 32'(aw_sel), 0);

    // FIFO full: fifth AW from requester 1 is held off.
    drive(0, 3'b010, 1, 3'b000, 3'b000, 0);
    check("full_flag", 32'(full), 1);
    check("full_aw_valid", 32'(m_awv), 0);
    check("full_aw_ready", 32'(awr_o), 0);

    // Burst from 0, length 2, while AW stays blocked.
    drive(0, 3'b010, 1, 3'b111, 3'b000, 1);
    check("b0_beat0_w_sel", 32'(w_sel), 0);
    check("b0_beat0_w_ready", 32'(wr_o), 32'b001);
    drive(0, 3'b010, 1, 3'b111, 3'b111, 1);
    check("b0_last_aw_blocked", 32'(m_awv), 0);
    // Pop took effect: fifth AW accepted now, burst from 1 (len 1) completes.
    drive(0, 3'b010, 1, 3'b111, 3'b111, 1);
    check("resume_aw_valid", 32'(m_awv), 1);
    check("resume_aw_sel", 32'(aw_sel), 1);
    check("resume_full", 32'(full), 0);
    check("b1_w_sel", 32'(w_sel), 1);
    // Burst from 2, length 3.
    drive(0, 3'b000, 0, 3'b111, 3'b000, 1);
    check("b2_beat0_w_sel", 32'(w_sel), 2);
    drive(0, 3'b000, 0, 3'b111, 3'b000, 1);
    check("b2_beat1_w_ready", 32'(wr_o), 32'b100);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("b2_last_w_sel", 32'(w_sel), 2);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("b0b_w_sel", 32'(w_sel), 0);

    // Queue now holds [1]; push 2 to reach count 2, then push+pop together.
    drive(0, 3'b100, 1, 3'b000, 3'b000, 0);
    check("pp_pre_sel", 32'(aw_sel), 2);
    drive(0, 3'b001, 1, 3'b111, 3'b111, 1);
    check("pp_aw_sel", 32'(aw_sel), 0);
    check("pp_w_sel", 32'(w_sel), 1);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("pp_head_next", 32'(w_sel), 2);
    check("pp_not_empty", 32'(empty), 0);
    check("pp_not_full", 32'(full), 0);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("pp_tail", 32'(w_sel), 0);

    // Requester 1 wins and is held while ready is low, despite others asserting.
    drive(0, 3'b010, 0, 3'b000, 3'b000, 0);
    check("hold_c0_sel", 32'(aw_sel), 1);
    check("hold_c0_ready", 32'(awr_o), 0);
    drive(0, 3'b011, 0, 3'b000, 3'b000, 0);
    check("hold_c1_sel", 32'(aw_sel), 1);
    drive(0, 3'b011, 0, 3'b000, 3'b000, 0);
    check("hold_c2_sel", 32'(aw_sel), 1);
    check("hold_c2_valid", 32'(m_awv), 1);
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("hold_grant_ready", 32'(awr_o), 32'b010);
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("hold_next_is_2", 32'(aw_sel), 2);
    drive(0, 3'b011, 1, 3'b000, 3'b000, 0);
    check("hold_then_0", 32'(aw_sel), 0);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("hold_w0", 32'(w_sel), 1);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("hold_w1", 32'(w_sel), 2);
    drive(0, 3'b000, 0, 3'b111, 3'b111, 1);
    check("hold_w2", 32'(w_sel), 0);

    // Empty FIFO, AW from 1 together with a single-beat W from 1.
    drive(0, 3'b010, 1, 3'b010, 3'b010, 1);
    check("ft_aw_sel", 32'(aw_sel), 1);
    if (FT) begin
      check("ft_w_ready", 32'(wr_o), 32'b010);
      check("ft_w_valid", 32'(m_wv), 1);
    end else begin
      check("noft_w_ready", 32'(wr_o), 0);
      check("noft_w_valid", 32'(m_wv), 0);
    end
    drive(0, 3'b000, 0, 3'b010, 3'b010, 1);
    if (FT) begin
      check("ft_stays_empty", 32'(empty), 1);
      check("ft_no_late_w", 32'(wr_o), 0);
    end else begin
      check("noft_pushed", 32'(empty), 0);
      check("noft_late_w", 32'(wr_o), 32'b010);
    end
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);
    check("ft_done_empty", 32'(empty), 1);
    // Non-last beat in the AW cycle still records the index.
    drive(0, 3'b100, 1, 3'b100, 3'b000, 1);
    check("ftnl_aw_sel", 32'(aw_sel), 2);
    drive(0, 3'b000, 0, 3'b100, 3'b100, 1);
    check("ftnl_pushed", 32'(empty), 0);
    check("ftnl_w_sel", 32'(w_sel), 2);
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);
    check("ftnl_empty", 32'(empty), 1);

    // Reset with an outstanding grant and mid-burst W activity.
    drive(0, 3'b111, 1, 3'b000, 3'b000, 0);
    check("rst_pre_sel", 32'(aw_sel), 0);
    drive(1, 3'b000, 0, 3'b001, 3'b000, 1);
    check("rst_pre_not_empty", 32'(empty), 0);
    drive(0, 3'b111, 0, 3'b000, 3'b000, 0);
    check("rst_post_empty", 32'(empty), 1);
    check("rst_post_prio", 32'(aw_sel), 0);
    drive(1, 3'b000, 0, 3'b000, 3'b000, 0);
    check("rst_hold_valid", 32'(m_awv), 1);
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);
    check("rst_clears_hold", 32'(m_awv), 0);
    drive(0, 3'b000, 0, 3'b000, 3'b000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
